// File: rtl/l1_port_arbiter_pkg.sv
// Shared state encoding and constants for the L1 port arbiter.
package l1_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DONE    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/l1_port_arbiter_if.sv
// Requester and L1 handshake bundle; slave = arbiter view, master = surrounding environment.
interface l1_port_arbiter_if #(
    parameter int ADDR_W = l1_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = l1_arb_pkg::DATA_W_DEF
);
    logic [ADDR_W-1:0] R0_addressBus;
    logic [DATA_W-1:0] R0_wdata;
    logic              R0_WE;
    logic              R0_request;
    logic [DATA_W-1:0] R0_rdata;
    logic              R0_ACK;

    logic [ADDR_W-1:0] R1_addressBus;
    logic [DATA_W-1:0] R1_wdata;
    logic              R1_WE;
    logic              R1_request;
    logic [DATA_W-1:0] R1_rdata;
    logic              R1_ACK;

    logic [ADDR_W-1:0] L1_addressBus;
    logic              L1_request;
    logic              L1_WE;
    logic              L1_ACK;

    modport slave (
        input  R0_addressBus, R0_wdata, R0_WE, R0_request,
        output R0_rdata, R0_ACK,
        input  R1_addressBus, R1_wdata, R1_WE, R1_request,
        output R1_rdata, R1_ACK,
        output L1_addressBus, L1_request, L1_WE,
        input  L1_ACK
    );

    modport master (
        output R0_addressBus, R0_wdata, R0_WE, R0_request,
        input  R0_rdata, R0_ACK,
        output R1_addressBus, R1_wdata, R1_WE, R1_request,
        input  R1_rdata, R1_ACK,
        input  L1_addressBus, L1_request, L1_WE,
        output L1_ACK
    );

endinterface

// File: rtl/l1_port_arbiter_rr_pick.sv
// Two-way round-robin winner selection; rr_ptr only matters when both request.
module l1_arb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic rr_ptr,
    output logic valid,
    output logic winner
);

    // Winner decode from the request pair and the fairness pointer.
    always_comb begin
        valid  = 1'b0;
        winner = 1'b0;
        case ({req1, req0})
            2'b01: begin
                valid  = 1'b1;
                winner = 1'b0;
            end
            2'b10: begin
                valid  = 1'b1;
                winner = 1'b1;
            end
            2'b11: begin
                valid  = 1'b1;
                winner = rr_ptr;
            end
            default: begin
                valid  = 1'b0;
                winner = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/l1_port_arbiter.sv
// Shares one L1 request/WE/ACK port between two page walkers with round-robin grant.
// Optional REQ-phase abort timer is enabled by defining ARB_TIMEOUT_EN.
module l1_port_arbiter import l1_arb_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    l1_port_arbiter_if.slave  bus,
    inout  wire  [DATA_W-1:0] L1_dataBus
`ifdef ARB_TIMEOUT_EN
    , output logic            Timeout_error
`endif
);

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              l1_req_q, l1_req_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
`ifdef ARB_TIMEOUT_EN
    logic [15:0]       cnt_q, cnt_d;
    logic              terr_q, terr_d;
`endif

    logic pick_valid_s;
    logic pick_winner_s;
    logic gnt_req_s;

    l1_arb_rr_pick u_pick (
        .req0   (bus.R0_request),
        .req1   (bus.R1_request),
        .rr_ptr (rr_ptr_q),
        .valid  (pick_valid_s),
        .winner (pick_winner_s)
    );

    assign gnt_req_s = gnt_q ? bus.R1_request : bus.R0_request;

    // Next-state and datapath computation for the four-phase handshake FSM.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        drop_d   = drop_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        l1_req_d = l1_req_q;
        ack0_d   = ack0_q;
        ack1_d   = ack1_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        terr_d   = terr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // L1_ACK must be low so the previous L1 cycle has fully closed.
                if (pick_valid_s && !bus.L1_ACK) begin
                    gnt_d    = pick_winner_s;
                    addr_d   = pick_winner_s ? bus.R1_addressBus : bus.R0_addressBus;
                    we_d     = pick_winner_s ? bus.R1_WE : bus.R0_WE;
                    wdata_d  = pick_winner_s ? bus.R1_wdata : bus.R0_wdata;
                    l1_req_d = 1'b1;
                    drop_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    cnt_d    = 16'd0;
`endif
                    state_d  = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                drop_d = drop_q | ~gnt_req_s;
                if (bus.L1_ACK) begin
                    l1_req_d = 1'b0;
                    if (drop_q || !gnt_req_s) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_DONE;
                        if (gnt_q) begin
                            ack1_d = 1'b1;
                            if (we_q == OP_READ) begin
                                rdata1_d = L1_dataBus;
                            end else begin
                                rdata1_d = rdata1_q;
                            end
                        end else begin
                            ack0_d = 1'b1;
                            if (we_q == OP_READ) begin
                                rdata0_d = L1_dataBus;
                            end else begin
                                rdata0_d = rdata0_q;
                            end
                        end
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    l1_req_d = 1'b0;
                    terr_d   = 1'b1;
                    if (drop_q || !gnt_req_s) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_DONE;
                        if (gnt_q) begin
                            ack1_d   = 1'b1;
                            rdata1_d = DATA_W'(ABORT_DATA);
                        end else begin
                            ack0_d   = 1'b1;
                            rdata0_d = DATA_W'(ABORT_DATA);
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`else
                else begin
                    state_d = ST_REQ;
                end
`endif
            end
            ST_DONE: begin
                if (!gnt_req_s) begin
                    ack0_d  = 1'b0;
                    ack1_d  = 1'b0;
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_RELEASE: begin
                if (!bus.L1_ACK) begin
                    rr_ptr_d = ~gnt_q;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= 1'b0;
            rr_ptr_q <= 1'b0;
            drop_q   <= 1'b0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            l1_req_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= 16'd0;
            terr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            drop_q   <= drop_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            l1_req_q <= l1_req_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            terr_q   <= terr_d;
`endif
        end
    end

    assign bus.R0_rdata      = rdata0_q;
    assign bus.R0_ACK        = ack0_q;
    assign bus.R1_rdata      = rdata1_q;
    assign bus.R1_ACK        = ack1_q;
    assign bus.L1_addressBus = addr_q;
    assign bus.L1_request    = l1_req_q;
    assign bus.L1_WE         = we_q;

    assign L1_dataBus = (l1_req_q && (we_q == OP_WRITE)) ? wdata_q : {DATA_W{1'bz}};

`ifdef ARB_TIMEOUT_EN
    assign Timeout_error = terr_q;
`endif

endmodule

// File: tb/tb_l1_port_arbiter.sv
// Self-checking bench for l1_port_arbiter: vector table, L1 memory model, per-requester scoreboards.
module tb_l1_port_arbiter;

    typedef struct {
        bit          who;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    wire  [31:0] L1_dataBus;
    logic        l1_drv_en = 1'b0;
    logic [31:0] l1_drv_val = 32'h0;
    logic        l1_hold = 1'b0;
    int          l1_delay = 0;
    int          l1_cnt = 0;
    int          l1_acks = 0;
    logic        l1_prev_req = 1'b0;
    logic [31:0] l1_last_addr = 32'h0;
    logic        l1_last_we = 1'b0;
    logic [31:0] l1_last_data = 32'h0;
    logic [31:0] mem [logic [31:0]];

    logic        r0_active = 1'b0;
    logic        r1_active = 1'b0;
    logic [31:0] sb0 [$];
    logic [31:0] sb1 [$];
    bit          served [$];

    int n_checks = 0;
    int n_fail   = 0;

    assign L1_dataBus = l1_drv_en ? l1_drv_val : 32'hzzzzzzzz;

    l1_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_TIMEOUT_EN
    logic timeout_error;
    l1_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .L1_dataBus    (L1_dataBus),
        .Timeout_error (timeout_error)
    );
`else
    l1_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .L1_dataBus (L1_dataBus)
    );
`endif

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic logic get_ack(input bit who);
        return who ? bus.R1_ACK : bus.R0_ACK;
    endfunction

    // L1 memory model: four-phase slave with programmable ACK delay and hold.
    always @(negedge clk) begin
        if (bus.L1_request && !l1_prev_req) begin
            check32("l1_overlap", {31'd0, bus.L1_ACK}, 32'd0);
        end
        if (bus.L1_request && !bus.L1_ACK && !l1_hold) begin
            if (l1_cnt >= l1_delay) begin
                l1_last_addr = bus.L1_addressBus;
                l1_last_we   = bus.L1_WE;
                l1_last_data = L1_dataBus;
                if (bus.L1_WE) begin
                    mem[bus.L1_addressBus] = L1_dataBus;
                end else begin
                    l1_drv_val = mem.exists(bus.L1_addressBus) ? mem[bus.L1_addressBus] : ~bus.L1_addressBus;
                    l1_drv_en  = 1'b1;
                end
                bus.L1_ACK = 1'b1;
                l1_acks++;
            end else begin
                l1_cnt++;
            end
        end else if (!bus.L1_request && bus.L1_ACK) begin
            bus.L1_ACK = 1'b0;
            l1_drv_en  = 1'b0;
        end
        if (!bus.L1_request) l1_cnt = 0;
        l1_prev_req = bus.L1_request;
    end

    // Any requester ACK must belong to an outstanding, still-held request.
    always @(negedge clk) begin
        if (bus.R0_ACK) check32("r0_ack_unowned", {31'd0, r0_active}, 32'd1);
        if (bus.R1_ACK) check32("r1_ack_unowned", {31'd0, r1_active}, 32'd1);
    end

    task automatic run_req(input bit who, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit chk_lat);
        int n;
        logic [31:0] exp_v;
        @(negedge clk);
        if (who) begin
            bus.R1_addressBus = addr; bus.R1_wdata = wdata; bus.R1_WE = we;
            bus.R1_request = 1'b1; r1_active = 1'b1; sb1.push_back(exp_rdata);
        end else begin
            bus.R0_addressBus = addr; bus.R0_wdata = wdata; bus.R0_WE = we;
            bus.R0_request = 1'b1; r0_active = 1'b1; sb0.push_back(exp_rdata);
        end
        if (chk_lat) begin
            @(negedge clk);
            check32("l1_req_latency", {31'd0, bus.L1_request}, 32'd1);
        end
        n = 0;
        while (!get_ack(who) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            fail_now(who ? "r1_ack_wait" : "r0_ack_wait");
        end else begin
            exp_v = who ? sb1.pop_front() : sb0.pop_front();
            check32(who ? "r1_rdata" : "r0_rdata", who ? bus.R1_rdata : bus.R0_rdata, exp_v);
            check32("l1_addr", l1_last_addr, addr);
            check32("l1_we", {31'd0, l1_last_we}, {31'd0, we});
            if (we) check32("l1_wdata", l1_last_data, wdata);
            served.push_back(who);
        end
        if (who) bus.R1_request = 1'b0; else bus.R0_request = 1'b0;
        n = 0;
        while (get_ack(who) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) fail_now("ack_release");
        if (who) r1_active = 1'b0; else r0_active = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check32({tag, "_r0_rdata"}, bus.R0_rdata, 32'h0);
        check32({tag, "_r1_rdata"}, bus.R1_rdata, 32'h0);
        check32({tag, "_acks"}, {30'd0, bus.R1_ACK, bus.R0_ACK}, 32'h0);
        check32({tag, "_l1_addr"}, bus.L1_addressBus, 32'h0);
        check32({tag, "_l1_req_we"}, {30'd0, bus.L1_request, bus.L1_WE}, 32'h0);
    endtask

    initial begin
        vec_t vecs [6];
        int   n;
        int   base;

        vecs[0] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0000_0000, 32'h0000_2000};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_3010, 32'hA5A5_A5A5, 32'h0000_0000};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_3010, 32'h0000_0000, 32'hA5A5_A5A5};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0000_2000};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h1234_5678};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_4000, 32'h0000_0000, 32'hFFFF_BFFF};

        bus.R0_addressBus = 32'h0; bus.R0_wdata = 32'h0; bus.R0_WE = 1'b0; bus.R0_request = 1'b0;
        bus.R1_addressBus = 32'h0; bus.R1_wdata = 32'h0; bus.R1_WE = 1'b0; bus.R1_request = 1'b0;
        bus.L1_ACK = 1'b0;
        mem[32'h0000_1004] = 32'h0000_2000;

        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            l1_delay = i % 3;
            run_req(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1'b1);
        end

        // Write followed by bus release: only the bench's value may appear afterwards.
        l1_delay = 2;
        run_req(1'b1, 1'b1, 32'h0000_3020, 32'h0F0F_0F0F, 32'hFFFF_BFFF, 1'b1);
        @(negedge clk);
        l1_drv_val = 32'h5A5A_5A5A;
        l1_drv_en  = 1'b1;
        #1;
        check32("bus_released", L1_dataBus, 32'h5A5A_5A5A);
        l1_drv_en = 1'b0;

        // Simultaneous requests, two rounds: R0 must win both if rr_ptr ends at 0.
        l1_delay = 1;
        for (int r = 0; r < 2; r++) begin
            served.delete();
            fork
                run_req(1'b0, 1'b0, (r == 0) ? 32'h0000_1004 : 32'h0000_0100, 32'h0,
                        (r == 0) ? 32'h0000_2000 : 32'h1234_5678, 1'b1);
                run_req(1'b1, 1'b0, (r == 0) ? 32'h0000_3020 : 32'h0000_3010, 32'h0,
                        (r == 0) ? 32'h0F0F_0F0F : 32'hA5A5_A5A5, 1'b0);
            join
            check32("rr_served_count", served.size(), 32'd2);
            if (served.size() == 2) begin
                check32("rr_first", {31'd0, served[0]}, 32'd0);
                check32("rr_second", {31'd0, served[1]}, 32'd1);
            end
        end

        // Requester abandons its request while L1 is still busy.
        l1_hold = 1'b1;
        l1_delay = 0;
        @(negedge clk);
        bus.R0_addressBus = 32'h0000_2222; bus.R0_WE = 1'b0; bus.R0_request = 1'b1; r0_active = 1'b1;
        @(negedge clk);
        check32("drop_l1_req", {31'd0, bus.L1_request}, 32'd1);
        @(negedge clk);
        bus.R0_request = 1'b0; r0_active = 1'b0;
        repeat (2) @(negedge clk);
        base = l1_acks;
        l1_hold = 1'b0;
        n = 0;
        while (l1_acks == base && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("drop_l1_ack_wait");
        repeat (4) @(negedge clk);
        check32("drop_l1_addr", l1_last_addr, 32'h0000_2222);
        check32("drop_l1_idle", {31'd0, bus.L1_request}, 32'd0);
        run_req(1'b1, 1'b0, 32'h0000_3010, 32'h0, 32'hA5A5_A5A5, 1'b1);

        // Reset in the middle of REQ drops the transaction.
        l1_hold = 1'b1;
        @(negedge clk);
        bus.R0_addressBus = 32'h0000_1004; bus.R0_WE = 1'b0; bus.R0_request = 1'b1; r0_active = 1'b1;
        repeat (3) @(negedge clk);
        check32("midreq_l1_req", {31'd0, bus.L1_request}, 32'd1);
        reset_n = 1'b0;
        bus.R0_request = 1'b0; r0_active = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check_outputs_zero("midreset");
        l1_hold = 1'b0;
        run_req(1'b0, 1'b0, 32'h0000_1004, 32'h0, 32'h0000_2000, 1'b1);

`ifdef ARB_TIMEOUT_EN
        // L1 never answers: abort after eight REQ cycles with the sticky error.
        l1_hold = 1'b1;
        @(negedge clk);
        bus.R0_addressBus = 32'h0000_5000; bus.R0_WE = 1'b0; bus.R0_request = 1'b1; r0_active = 1'b1;
        @(negedge clk);
        check32("to_l1_req", {31'd0, bus.L1_request}, 32'd1);
        n = 0;
        while (!bus.R0_ACK && n < 50) begin
            @(negedge clk);
            n++;
        end
        check32("to_cycles", n, 32'd8);
        check32("to_rdata", bus.R0_rdata, 32'hDEAD_BEEF);
        check32("to_error", {31'd0, timeout_error}, 32'd1);
        check32("to_l1_req_low", {31'd0, bus.L1_request}, 32'd0);
        bus.R0_request = 1'b0;
        repeat (4) @(negedge clk);
        r0_active = 1'b0;
        check32("to_sticky", {31'd0, timeout_error}, 32'd1);
        l1_hold = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check32("to_cleared", {31'd0, timeout_error}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
